// File: rtl/mult_pkg.sv
// Shared types and defaults for the shift-add signed multiplier controller.
package mult_pkg;

  // Default multiplier width, which is also the number of add/shift iterations.
  localparam int MULT_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CLRA  = 3'd2,
    ADD   = 3'd3,
    SHIFT = 3'd4,
    HOLD  = 3'd5
  } state_t;

  // True for the states that make up an active multiply.
  function automatic logic state_is_busy(input state_t s);
    return (s == CLRA) || (s == ADD) || (s == SHIFT);
  endfunction

endpackage

// File: rtl/mult_iter_counter.sv
// Iteration counter for the multiplier: cleared on entry to a multiply,
// incremented once per shift, flags the final (MSB) iteration.
module mult_iter_counter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic Clk,
  input  logic reset,
  input  logic clear_i,
  input  logic inc_i,
  output logic last_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Clear has priority; the count only advances when told to.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge Clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last_o = (count_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/mult_controller.sv
// Control FSM for the shift-add signed multiplier datapath. One add-or-subtract
// and one arithmetic right shift per multiplier bit; the final bit subtracts
// because the multiplier MSB carries negative weight.
module mult_controller
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic Clk,
  input  logic reset,
  input  logic Run,
  input  logic ClearA_LoadB,
  input  logic M,
  output logic Ld_B,
  output logic Clr_A,
  output logic Add,
  output logic Sub,
  output logic Shift_En,
  output logic Busy,
  output logic Done
);

  state_t state_q;
  state_t state_d;
  logic   last_iter;

  mult_iter_counter #(
    .WIDTH (WIDTH)
  ) u_iter_counter (
    .Clk     (Clk),
    .reset   (reset),
    .clear_i (state_q == CLRA),
    .inc_i   (state_q == SHIFT),
    .last_o  (last_iter)
  );

  // State register; reset returns to IDLE and abandons any partial product.
  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and strobe decode; Add/Sub additionally depend on M.
  always_comb begin
    state_d  = state_q;
    Ld_B     = 1'b0;
    Clr_A    = 1'b0;
    Add      = 1'b0;
    Sub      = 1'b0;
    Shift_En = 1'b0;
    Busy     = state_is_busy(state_q);
    Done     = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Run wins over a simultaneous load request.
        if (Run) begin
          state_d = CLRA;
        end else if (ClearA_LoadB) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        Ld_B    = 1'b1;
        Clr_A   = 1'b1;
        state_d = IDLE;
      end
      CLRA: begin
        Clr_A   = 1'b1;
        state_d = ADD;
      end
      ADD: begin
        if (M) begin
          Sub = last_iter;
          Add = ~last_iter;
        end
        state_d = SHIFT;
      end
      SHIFT: begin
        Shift_En = 1'b1;
        state_d  = last_iter ? HOLD : ADD;
      end
      HOLD: begin
        // Product stays presented until Run is released.
        Done = 1'b1;
        if (!Run) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
